pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised successor to the single-cycle PC controller. It sequences the program counter for the BeeF core and handles loops in hardware:
- CBF/CBB use a return-address stack.
- CBF on a zero cell triggers a nesting-aware forward skip.
- A configurable number of bubble cycles follows each issue.

It sits between instruction fetch and the PC register, and drives pc_next, the PC write enable and the pipeline bubble.

Parameters:
INSTR_W, 9, instruction width (op_code'(instruction) cast).
PC_W, 16, program counter width.
STACK_DEPTH, 8, loop return-address stack entries (power of two, >=2).
SKIP_MAX, 255, maximum nesting depth tracked during a forward skip.
BUBBLE_CYCLES, 1, bubble cycles inserted after every issued instruction (0 allowed).

Ports:
clk  input  1  clock, all state on posedge.
reset  input  1  synchronous, active-high reset.
instruction  input  INSTR_W  current instruction from fetch.
instr_valid  input  1  instruction is valid this cycle.
pc  input  PC_W  current PC register value.
cond_zero  input  1  data cell under pointer is zero.
stall_in  input  1  external stall; freezes the block.
pc_next  output  PC_W  value to load into the PC.
write_enable  output  1  PC load strobe (issue cycle only).
write_src  output  1  1 = loop target selected, 0 = pc+1.
bubble  output  1  downstream must treat this cycle as a NOP.
skipping  output  1  forward-skip in progress; execute units must suppress side effects.
error  output  1  sticky stack overflow/underflow or skip-depth overflow.
err_code  output  2  0 none, 1 stack overflow, 2 stack underflow, 3 skip overflow.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - state=RUN; stack empty; skip depth=0; bubble counter=0.
  - All outputs 0, including pc_next=0 and write_enable=0.
- States: RUN, BUBBLE, SKIP, SKIP_BUBBLE, ERROR.
- Issue cycle: state RUN or SKIP, instr_valid=1, stall_in=0.
  - write_enable=1 combinationally in the same cycle; zero latency.
  - Next state is BUBBLE/SKIP_BUBBLE when BUBBLE_CYCLES>0, otherwise it stays in RUN/SKIP.
- BUBBLE / SKIP_BUBBLE:
  - bubble=1 and write_enable=0 for exactly BUBBLE_CYCLES non-stalled cycles.
  - Then return to RUN/SKIP.
- stall_in=1:
  - write_enable=0.
  - bubble holds its current value.
  - All state, counters and stack are frozen.
- instr_valid=0 in RUN/SKIP: write_enable=0, no state change.
- RUN decode (pc_next=pc+1, write_src=0 unless stated):
  - CBF, cond_zero=0: push pc. If the stack is full: ERROR, code 1, no push, write_enable forced 0.
  - CBF, cond_zero=1: enter SKIP with depth=1. No push.
  - CBB, cond_zero=0: pc_next=top+1, write_src=1. No pop. If the stack is empty: ERROR, code 2.
  - CBB, cond_zero=1: pop. If the stack is empty: ERROR, code 2.
  - Any other op: pc+1.
- SKIP:
  - skipping=1; pc_next=pc+1 on each issue; stack untouched.
  - CBF: depth+1. If that would exceed SKIP_MAX: ERROR, code 3.
  - CBB: depth-1. At 0, return to RUN after this issue (and its bubbles); skipping drops on the first RUN cycle.
  - cond_zero is ignored.
- ERROR:
  - write_enable=0, bubble=0, error=1, err_code held.
  - Exit only by reset.
- Arithmetic:
  - pc+1 and top+1 wrap modulo 2^PC_W.
  - The stack pointer is clog2(STACK_DEPTH)+1 bits with an explicit full flag (count==STACK_DEPTH).
- Write/read ordering: a push is visible to a CBB issued on the next issue cycle. Same-cycle push and pop cannot occur (one issue per cycle).
- Reset mid-skip or mid-bubble: all state is discarded, and the next cycle is RUN with an empty stack.

Decomposition:
- Package definitions:
  - Uses the existing op_code members CBF/CBB.
  - Add pc_seq_state_t (5 states) and pc_seq_err_t (2-bit codes above).
- One sub-module: loop_stack, a parametrised LIFO.
  - Ports: clk, reset, push, pop, din, top, empty, full.
  - The sequencer owns all decode and FSM logic.

Test Plan:
- Reset, then RUN with an ADD at pc=5, BUBBLE_CYCLES=1 -> pc_next=6, write_enable=1 for one cycle, then bubble=1 for one cycle; all outputs 0 during reset.
- Loop: CBF at pc=10 with cond_zero=0, later CBB at pc=14 with cond_zero=0 -> pc_next=11, write_src=1. The same CBB with cond_zero=1 -> pop, pc_next=15, stack empty.
- Forward skip: CBF at pc=20 with cond_zero=1, then the stream CBF, ADD, CBB, CBB -> skipping=1 for all four issues, depth 1→2→2→1→0. The next instruction at pc=25 issues in RUN with skipping=0.
- Overflow: STACK_DEPTH=2, issue three CBF with cond_zero=0 -> third issue gives error=1, err_code=1, write_enable=0; the state holds for 10 cycles until reset.
- Underflow: CBB with cond_zero=1 on an empty stack -> err_code=2. Also check a separate run with SKIP_MAX=1 and a nested CBF during skip -> err_code=3.
- Stall plus reset: assert stall_in for 3 cycles mid-BUBBLE -> bubble held at 1, counter frozen, and the bubble completes after release. Asserting reset during SKIP -> the next cycle is RUN, skipping=0, stack empty.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the BeeF program-counter sequencer: opcodes, FSM states
// and sticky error codes.
package pc_sequencer_pkg;

    localparam int OP_W = 9;

    typedef enum logic [OP_W-1:0] {
        NOP   = 9'd0,
        ADD   = 9'd1,
        SUB   = 9'd2,
        LEFT  = 9'd3,
        RIGHT = 9'd4,
        INP   = 9'd5,
        OUTP  = 9'd6,
        CBF   = 9'd7,
        CBB   = 9'd8
    } op_code;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_BUBBLE,
        ST_SKIP,
        ST_SKIP_BUBBLE,
        ST_ERROR
    } pc_seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_STACK_OVF = 2'd1,
        ERR_STACK_UDF = 2'd2,
        ERR_SKIP_OVF  = 2'd3
    } pc_seq_err_t;

endpackage

// File: rtl/pc_sequencer_loop_stack.sv
// Return-address LIFO for CBF/CBB loops. Push and pop are ignored when the
// stack is full or empty respectively; the owner flags those as errors.
module loop_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = mem_q[AW'(cnt_q - 1'b1)];

    always_comb begin
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[cnt_q[AW-1:0]] = din;
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; the count alone defines what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the BeeF core: zero-latency issue, hardware
// loops via a return-address stack, nesting-aware forward skip, post-issue bubbles.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int INSTR_W       = 9,
    parameter int PC_W          = 16,
    parameter int STACK_DEPTH   = 8,
    parameter int SKIP_MAX      = 255,
    parameter int BUBBLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    input  logic [PC_W-1:0]    pc,
    input  logic               cond_zero,
    input  logic               stall_in,
    output logic [PC_W-1:0]    pc_next,
    output logic               write_enable,
    output logic               write_src,
    output logic               bubble,
    output logic               skipping,
    output logic               error,
    output logic [1:0]         err_code
);
    localparam int  SD_W       = $clog2(SKIP_MAX + 1);
    localparam int  BC_W       = (BUBBLE_CYCLES > 1) ? $clog2(BUBBLE_CYCLES) : 1;
    localparam bit  HAS_BUBBLE = (BUBBLE_CYCLES > 0);
    localparam logic [BC_W-1:0] BC_LOAD  = HAS_BUBBLE ? BC_W'(BUBBLE_CYCLES - 1) : '0;
    localparam logic [SD_W-1:0] SKIP_LIM = SD_W'(SKIP_MAX);

    pc_seq_state_t   state_q, state_d;
    logic [SD_W-1:0] depth_q, depth_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    pc_seq_err_t     err_q, err_d;

    logic [OP_W-1:0] op_bits;
    op_code          op;
    logic            issue;
    logic            push, pop;
    logic [PC_W-1:0] top;
    logic            empty, full;
    logic [PC_W-1:0] pc_next_c;
    logic            we_c, src_c;
    logic            err_hit;
    pc_seq_err_t     err_sel;

    assign op_bits = OP_W'(instruction);
    assign op      = op_code'(op_bits);
    assign issue   = instr_valid && !stall_in
                     && (state_q == ST_RUN || state_q == ST_SKIP);

    loop_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_loop_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .top   (top),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        bcnt_d    = bcnt_q;
        err_d     = err_q;
        push      = 1'b0;
        pop       = 1'b0;
        pc_next_c = pc + PC_W'(1);
        we_c      = 1'b0;
        src_c     = 1'b0;
        err_hit   = 1'b0;
        err_sel   = ERR_NONE;

        case (state_q)
            ST_RUN: begin
                if (issue) begin
                    we_c    = 1'b1;
                    bcnt_d  = BC_LOAD;
                    state_d = HAS_BUBBLE ? ST_BUBBLE : ST_RUN;
                    case (op)
                        CBF: begin
                            if (cond_zero) begin
                                depth_d = SD_W'(1);
                                state_d = HAS_BUBBLE ? ST_SKIP_BUBBLE : ST_SKIP;
                            end else if (full) begin
                                err_hit = 1'b1;
                                err_sel = ERR_STACK_OVF;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        CBB: begin
                            if (empty) begin
                                err_hit = 1'b1;
                                err_sel = ERR_STACK_UDF;
                            end else if (cond_zero) begin
                                pop = 1'b1;
                            end else begin
                                pc_next_c = top + PC_W'(1);
                                src_c     = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SKIP: begin
                if (issue) begin
                    we_c    = 1'b1;
                    bcnt_d  = BC_LOAD;
                    state_d = HAS_BUBBLE ? ST_SKIP_BUBBLE : ST_SKIP;
                    case (op)
                        CBF: begin
                            if (depth_q == SKIP_LIM) begin
                                err_hit = 1'b1;
                                err_sel = ERR_SKIP_OVF;
                            end else begin
                                depth_d = depth_q + SD_W'(1);
                            end
                        end
                        CBB: begin
                            depth_d = depth_q - SD_W'(1);
                            if (depth_q == SD_W'(1) && !HAS_BUBBLE) begin
                                state_d = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUBBLE, ST_SKIP_BUBBLE: begin
                if (!stall_in) begin
                    if (bcnt_q == '0) begin
                        // depth reaching zero during the skip bubbles means the skip is over
                        if (state_q == ST_BUBBLE || depth_q == '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end else begin
                        bcnt_d = bcnt_q - BC_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (err_hit) begin
            state_d = ST_ERROR;
            err_d   = err_sel;
            we_c    = 1'b0;
            src_c   = 1'b0;
            push    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            depth_q <= '0;
            bcnt_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // Reset forces every output low in the same cycle, ahead of any decode.
    assign pc_next      = reset ? '0 : pc_next_c;
    assign write_enable = !reset && we_c;
    assign write_src    = !reset && src_c;
    assign bubble       = !reset && (state_q == ST_BUBBLE || state_q == ST_SKIP_BUBBLE);
    assign skipping     = !reset && (state_q == ST_SKIP || state_q == ST_SKIP_BUBBLE);
    assign error        = !reset && (state_q == ST_ERROR);
    assign err_code     = reset ? 2'd0 : err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table on the default build, plus
// hand sequences on a 2-deep-stack build and a SKIP_MAX=1, zero-bubble build.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  instruction = '0;
    logic        instr_valid = 1'b0;
    logic [15:0] pc = '0;
    logic        cond_zero = 1'b0;
    logic        stall_in = 1'b0;

    logic [15:0] a_pn, b_pn, c_pn;
    logic        a_we, b_we, c_we, a_src, b_src, c_src;
    logic        a_bub, b_bub, c_bub, a_sk, b_sk, c_sk, a_er, b_er, c_er;
    logic [1:0]  a_ec, b_ec, c_ec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .cond_zero(cond_zero), .stall_in(stall_in),
        .pc_next(a_pn), .write_enable(a_we), .write_src(a_src), .bubble(a_bub),
        .skipping(a_sk), .error(a_er), .err_code(a_ec)
    );

    pc_sequencer #(.STACK_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .cond_zero(cond_zero), .stall_in(stall_in),
        .pc_next(b_pn), .write_enable(b_we), .write_src(b_src), .bubble(b_bub),
        .skipping(b_sk), .error(b_er), .err_code(b_ec)
    );

    pc_sequencer #(.SKIP_MAX(1), .BUBBLE_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .cond_zero(cond_zero), .stall_in(stall_in),
        .pc_next(c_pn), .write_enable(c_we), .write_src(c_src), .bubble(c_bub),
        .skipping(c_sk), .error(c_er), .err_code(c_ec)
    );

    typedef struct {
        logic        rst, stall, valid, cz;
        logic [8:0]  ins;
        logic [15:0] pc;
        bit          cpc;
        logic [15:0] epc;
        logic        esrc;
        bit          cwe;
        logic        ewe, ebub, eskip;
        bit          cerr;
        logic        eerr;
        logic [1:0]  ecode;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic stall, logic valid, logic [8:0] ins,
                                logic [15:0] vpc, logic cz, bit cpc, logic [15:0] epc,
                                logic esrc, bit cwe, logic ewe, logic ebub, logic eskip,
                                bit cerr, logic eerr, logic [1:0] ecode);
        vec_t v;
        v.rst = rst; v.stall = stall; v.valid = valid; v.ins = ins; v.pc = vpc; v.cz = cz;
        v.cpc = cpc; v.epc = epc; v.esrc = esrc; v.cwe = cwe; v.ewe = ewe;
        v.ebub = ebub; v.eskip = eskip; v.cerr = cerr; v.eerr = eerr; v.ecode = ecode;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic rst, logic stall, logic valid, logic [8:0] ins,
                         logic [15:0] vpc, logic cz);
        @(negedge clk);
        reset = rst; stall_in = stall; instr_valid = valid;
        instruction = ins; pc = vpc; cond_zero = cz;
        #1;
    endtask

    task automatic check(string nm, int w, bit cpc, logic [15:0] epc, logic esrc,
                         bit cwe, logic ewe, logic ebub, logic eskip,
                         bit cerr, logic eerr, logic [1:0] ecode);
        logic [15:0] pn;
        logic        we, src, bub, sk, er;
        logic [1:0]  ec;
        bit          bad;
        case (w)
            0: begin pn = a_pn; we = a_we; src = a_src; bub = a_bub; sk = a_sk; er = a_er; ec = a_ec; end
            1: begin pn = b_pn; we = b_we; src = b_src; bub = b_bub; sk = b_sk; er = b_er; ec = b_ec; end
            default: begin pn = c_pn; we = c_we; src = c_src; bub = c_bub; sk = c_sk; er = c_er; ec = c_ec; end
        endcase
        bad = 1'b0;
        if (cpc && (pn !== epc || src !== esrc)) bad = 1'b1;
        if (cwe && we !== ewe) bad = 1'b1;
        if (bub !== ebub || sk !== eskip) bad = 1'b1;
        if (cerr && (er !== eerr || ec !== ecode)) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got pc_next=%h src=%b we=%b bubble=%b skip=%b err=%b code=%0d; want pc_next=%h src=%b we=%b bubble=%b skip=%b err=%b code=%0d",
                     nm, pn, src, we, bub, sk, er, ec, epc, esrc, ewe, ebub, eskip, eerr, ecode);
        end
    endtask

    initial begin
        // rst stl vld ins   pc      cz | cpc epc     src | cwe we | bub skp | cerr er code
        add(1, 0, 1, ADD,   16'd5,  0,  1, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd5,  0,  1, 16'd6,  0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd6,  0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd6,  0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, CBF,   16'd10, 0,  1, 16'd11, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd11, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd14, 0,  1, 16'd11, 1,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd11, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd14, 1,  1, 16'd15, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd15, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd15, 1,  0, 16'd0,  0,  0, 0,  0, 0,  0, 0, 0);
        add(0, 0, 0, ADD,   16'd16, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 1, 2);
        add(0, 0, 1, ADD,   16'd16, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 1, 2);
        add(1, 0, 1, ADD,   16'd16, 0,  1, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, CBF,   16'd20, 1,  1, 16'd21, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd21, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, CBF,   16'd21, 0,  1, 16'd22, 0,  1, 1,  0, 1,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd22, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd22, 0,  1, 16'd23, 0,  1, 1,  0, 1,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd23, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd23, 0,  1, 16'd24, 0,  1, 1,  0, 1,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd24, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd24, 1,  1, 16'd25, 0,  1, 1,  0, 1,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd25, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd25, 0,  1, 16'd26, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd26, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, ADD,   16'hFFFF,0, 1, 16'd0,  0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd0,  0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBF,   16'hFFFF,0, 1, 16'd0,  0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd0,  0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd3,  0,  1, 16'd0,  1,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd0,  0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 1, CBF,   16'd40, 1,  1, 16'd41, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd41, 0,  0, 16'd0,  0,  1, 0,  1, 1,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd41, 0,  1, 16'd42, 0,  1, 1,  0, 1,  1, 0, 0);
        add(1, 0, 1, ADD,   16'd42, 0,  1, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd42, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, CBB,   16'd42, 1,  0, 16'd0,  0,  0, 0,  0, 0,  0, 0, 0);
        add(0, 0, 0, ADD,   16'd43, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 1, 2);
        add(1, 0, 0, ADD,   16'd43, 0,  1, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd50, 0,  1, 16'd51, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 1, 1, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 1, 1, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 1, 1, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 1, 1, ADD,   16'd51, 0,  0, 16'd0,  0,  1, 0,  0, 0,  1, 0, 0);
        add(0, 0, 1, ADD,   16'd51, 0,  1, 16'd52, 0,  1, 1,  0, 0,  1, 0, 0);
        add(0, 0, 0, ADD,   16'd52, 0,  0, 16'd0,  0,  1, 0,  1, 0,  1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].ins, vecs[i].pc, vecs[i].cz);
            check($sformatf("vec%0d", i), 0, vecs[i].cpc, vecs[i].epc, vecs[i].esrc,
                  vecs[i].cwe, vecs[i].ewe, vecs[i].ebub, vecs[i].eskip,
                  vecs[i].cerr, vecs[i].eerr, vecs[i].ecode);
        end

        // Stack overflow on the 2-deep build; the 8-deep build accepts the same stream.
        drive(1, 0, 0, ADD, 16'd60, 0);
        check("ovf_reset", 1, 1, 16'd0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, CBF, 16'(60 + k), 0);
            if (k < 2) begin
                check($sformatf("ovf_push%0d", k), 1, 1, 16'(61 + k), 0, 1, 1, 0, 0, 1, 0, 0);
                drive(0, 0, 0, ADD, 16'(61 + k), 0);
                check($sformatf("ovf_bub%0d", k), 1, 0, 16'd0, 0, 1, 0, 1, 0, 1, 0, 0);
            end else begin
                check("ovf_issue", 1, 0, 16'd0, 0, 1, 0, 0, 0, 0, 0, 0);
                check("ovf_deep_ok", 0, 1, 16'd63, 0, 1, 1, 0, 0, 1, 0, 0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, ADD, 16'd63, 0);
            check($sformatf("ovf_hold%0d", k), 1, 0, 16'd0, 0, 1, 0, 0, 0, 1, 1, 1);
        end
        drive(1, 0, 1, ADD, 16'd63, 0);
        check("ovf_clear", 1, 1, 16'd0, 0, 1, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, ADD, 16'd63, 0);
        check("ovf_after", 1, 0, 16'd0, 0, 1, 0, 0, 0, 1, 0, 0);

        // Zero-bubble build with SKIP_MAX=1: back-to-back issue, skip exit, skip overflow.
        drive(1, 0, 0, ADD, 16'd80, 0);
        drive(0, 0, 1, ADD, 16'd80, 0);
        check("nb_issue0", 2, 1, 16'd81, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, ADD, 16'd81, 0);
        check("nb_issue1", 2, 1, 16'd82, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, CBF, 16'd82, 1);
        check("nb_skip_in", 2, 1, 16'd83, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, CBB, 16'd83, 0);
        check("nb_skip_cbb", 2, 1, 16'd84, 0, 1, 1, 0, 1, 1, 0, 0);
        drive(0, 0, 1, ADD, 16'd84, 0);
        check("nb_run_again", 2, 1, 16'd85, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, CBF, 16'd85, 1);
        check("sk_enter", 2, 1, 16'd86, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, CBF, 16'd86, 0);
        check("sk_ovf_issue", 2, 0, 16'd0, 0, 1, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, ADD, 16'd87, 0);
        check("sk_ovf_err", 2, 0, 16'd0, 0, 1, 0, 0, 0, 1, 1, 3);
        drive(1, 0, 0, ADD, 16'd87, 0);
        check("sk_ovf_clear", 2, 1, 16'd0, 0, 1, 0, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
